// File: rtl/elevator_pkg.sv
// Shared types and constant helpers for the elevator call registry.
package elevator_pkg;

   typedef enum logic [1:0] {
      CALL_CAR  = 2'd0,
      CALL_UP   = 2'd1,
      CALL_DOWN = 2'd2
   } call_type_e;

   // Width of a floor index; never less than one bit.
   function automatic int unsigned floor_w(input int unsigned floors);
      return (floors > 1) ? $clog2(floors) : 1;
   endfunction

   // Saturation value of an age counter of the given width.
   function automatic int unsigned age_sat(input int unsigned width);
      return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
   endfunction

   // Top floor has no hall-up button, floor 0 has no hall-down button.
   function automatic bit call_exists(input call_type_e kind, input int unsigned floor,
                                      input int unsigned floors);
      case (kind)
         CALL_UP:   return floor < floors - 1;
         CALL_DOWN: return floor > 0;
         default:   return floor < floors;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: one accept pulse per high period after DEBOUNCE_CYCLES high samples.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic accept
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || !raw) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Fires on the sample that takes the count to its limit, so the call latches on that same edge.
   assign accept = raw && (cnt == CNT_LAST);

endmodule

// File: rtl/elevator_call_registry.sv
// Debounced call register with per-floor wait ages, direction summaries and oldest-call selection.
module elevator_call_registry
   import elevator_pkg::*;
#(
   parameter  int unsigned FLOORS          = 8,
   parameter  int unsigned DEBOUNCE_CYCLES = 4,
   parameter  int unsigned AGE_WIDTH       = 8,
   localparam int unsigned FLOOR_W         = floor_w(FLOORS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  car_btn,
   input  logic [FLOORS-2:0]  hall_up_btn,
   input  logic [FLOORS-1:1]  hall_down_btn,
   input  logic [FLOORS-1:0]  block_mask,
   input  logic               service_mode,
   input  logic [FLOORS-1:0]  clear_car,
   input  logic [FLOORS-2:0]  clear_up,
   input  logic [FLOORS-1:1]  clear_down,
   input  logic [FLOOR_W-1:0] current_floor,
   output logic [FLOORS-1:0]  car_calls,
   output logic [FLOORS-2:0]  up_calls,
   output logic [FLOORS-1:1]  down_calls,
   output logic               any_above,
   output logic               any_below,
   output logic               any_at,
   output logic [FLOOR_W-1:0] oldest_floor,
   output logic               oldest_valid
);

   localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(age_sat(AGE_WIDTH));

   logic [FLOORS-1:0]    car_acc;
   logic [FLOORS-2:0]    up_acc;
   logic [FLOORS-1:1]    down_acc;
   logic [FLOORS-1:0]    pend;
   logic [AGE_WIDTH-1:0] age [FLOORS];
   logic [AGE_WIDTH-1:0] best_age;
   logic [FLOOR_W-1:0]   best_idx;
   logic                 found;

   for (genvar f = 0; f < FLOORS; f++) begin : g_car_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw    (car_btn[f]),
         .accept (car_acc[f])
      );
   end

   for (genvar f = 0; f < FLOORS - 1; f++) begin : g_up_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw    (hall_up_btn[f]),
         .accept (up_acc[f])
      );
   end

   for (genvar f = 1; f < FLOORS; f++) begin : g_down_db
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk    (clk),
         .reset  (reset),
         .raw    (hall_down_btn[f]),
         .accept (down_acc[f])
      );
   end

   // Drop beats clear, clear beats press; a press on a blocked floor is simply lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         car_calls  <= '0;
         up_calls   <= '0;
         down_calls <= '0;
      end else begin
         car_calls <= (car_calls | car_acc) & ~clear_car & ~block_mask;
         if (service_mode) begin
            up_calls   <= '0;
            down_calls <= '0;
         end else begin
            up_calls   <= (up_calls | up_acc) & ~clear_up & ~block_mask[FLOORS-2:0];
            down_calls <= (down_calls | down_acc) & ~clear_down & ~block_mask[FLOORS-1:1];
         end
      end
   end

   for (genvar f = 0; f < FLOORS; f++) begin : g_pend
      logic up_bit;
      logic down_bit;
      if (call_exists(CALL_UP, f, FLOORS)) begin : g_up
         assign up_bit = up_calls[f];
      end else begin : g_no_up
         assign up_bit = 1'b0;
      end
      if (call_exists(CALL_DOWN, f, FLOORS)) begin : g_down
         assign down_bit = down_calls[f];
      end else begin : g_no_down
         assign down_bit = 1'b0;
      end
      assign pend[f] = car_calls[f] | up_bit | down_bit;
   end

   always_ff @(posedge clk) begin
      for (int unsigned f = 0; f < FLOORS; f++) begin
         if (reset || !pend[f]) begin
            age[f] <= '0;
         end else if (age[f] != AGE_MAX) begin
            age[f] <= age[f] + 1'b1;
         end
      end
   end

   // Strictly-greater comparison keeps the lowest index on ties.
   always_comb begin
      best_age = '0;
      best_idx = '0;
      found    = 1'b0;
      for (int unsigned f = 0; f < FLOORS; f++) begin
         if (pend[f] && (!found || (age[f] > best_age))) begin
            found    = 1'b1;
            best_age = age[f];
            best_idx = FLOOR_W'(f);
         end
      end
   end

   assign oldest_floor = best_idx;
   assign oldest_valid = |pend;

   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      any_at    = 1'b0;
      if (32'(current_floor) < FLOORS) begin
         for (int unsigned f = 0; f < FLOORS; f++) begin
            if (pend[f]) begin
               if (f > 32'(current_floor)) any_above = 1'b1;
               if (f < 32'(current_floor)) any_below = 1'b1;
               if (f == 32'(current_floor)) any_at = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_elevator_call_registry.sv
// Directed and randomized checks of elevator_call_registry against a behavioural call/age model.
module tb_elevator_call_registry;

   localparam int NF   = 8;
   localparam int DB   = 4;
   localparam int AMAX = 255;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] car_btn;
   logic [6:0] hall_up_btn;
   logic [7:1] hall_down_btn;
   logic [7:0] block_mask;
   logic       service_mode;
   logic [7:0] clear_car;
   logic [6:0] clear_up;
   logic [7:1] clear_down;
   logic [2:0] current_floor;
   logic [7:0] car_calls;
   logic [6:0] up_calls;
   logic [7:1] down_calls;
   logic       any_above, any_below, any_at;
   logic [2:0] oldest_floor;
   logic       oldest_valid;

   // Second instance: six floors, so out-of-range cabin positions are representable.
   logic [5:0] car_btn_b;
   logic [2:0] current_floor_b;
   logic [5:0] car_calls_b;
   logic [4:0] up_calls_b;
   logic [5:1] down_calls_b;
   logic       any_above_b, any_below_b, any_at_b;
   logic [2:0] oldest_floor_b;
   logic       oldest_valid_b;

   always #5 clk = ~clk;

   elevator_call_registry #(.FLOORS(8), .DEBOUNCE_CYCLES(4), .AGE_WIDTH(8)) u_dut (
      .clk(clk), .reset(reset), .car_btn(car_btn), .hall_up_btn(hall_up_btn),
      .hall_down_btn(hall_down_btn), .block_mask(block_mask), .service_mode(service_mode),
      .clear_car(clear_car), .clear_up(clear_up), .clear_down(clear_down),
      .current_floor(current_floor), .car_calls(car_calls), .up_calls(up_calls),
      .down_calls(down_calls), .any_above(any_above), .any_below(any_below), .any_at(any_at),
      .oldest_floor(oldest_floor), .oldest_valid(oldest_valid)
   );

   elevator_call_registry #(.FLOORS(6), .DEBOUNCE_CYCLES(1), .AGE_WIDTH(4)) u_dut_b (
      .clk(clk), .reset(reset), .car_btn(car_btn_b), .hall_up_btn(5'h00),
      .hall_down_btn(5'h00), .block_mask(6'h00), .service_mode(1'b0),
      .clear_car(6'h00), .clear_up(5'h00), .clear_down(5'h00),
      .current_floor(current_floor_b), .car_calls(car_calls_b), .up_calls(up_calls_b),
      .down_calls(down_calls_b), .any_above(any_above_b), .any_below(any_below_b),
      .any_at(any_at_b), .oldest_floor(oldest_floor_b), .oldest_valid(oldest_valid_b)
   );

   int vectors = 0;
   int miscompares = 0;

   int run_car[NF], run_up[NF], run_dn[NF];
   bit m_car[NF], m_up[NF], m_dn[NF];
   int m_age[NF];

   task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit m_pend(input int f);
      return m_car[f] || (f < NF - 1 && m_up[f]) || (f > 0 && m_dn[f]);
   endfunction

   // Length of the current high run, capped at the acceptance threshold.
   function automatic int next_run(input int run, input bit raw);
      if (!raw) return 0;
      return (run >= DB) ? DB : run + 1;
   endfunction

   task automatic model_step();
      bit pend_old[NF];
      bit acc;
      int nr;
      if (reset) begin
         for (int f = 0; f < NF; f++) begin
            run_car[f] = 0; run_up[f] = 0; run_dn[f] = 0;
            m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0; m_age[f] = 0;
         end
      end else begin
         for (int f = 0; f < NF; f++) pend_old[f] = m_pend(f);
         for (int f = 0; f < NF; f++) begin
            m_age[f] = pend_old[f] ? ((m_age[f] >= AMAX) ? AMAX : m_age[f] + 1) : 0;

            nr = next_run(run_car[f], car_btn[f]);
            acc = (run_car[f] != DB) && (nr == DB);
            run_car[f] = nr;
            if (block_mask[f] || clear_car[f]) m_car[f] = 0;
            else if (acc) m_car[f] = 1;

            if (f < NF - 1) begin
               nr = next_run(run_up[f], hall_up_btn[f]);
               acc = (run_up[f] != DB) && (nr == DB);
               run_up[f] = nr;
               if (block_mask[f] || service_mode || clear_up[f]) m_up[f] = 0;
               else if (acc) m_up[f] = 1;
            end
            if (f > 0) begin
               nr = next_run(run_dn[f], hall_down_btn[f]);
               acc = (run_dn[f] != DB) && (nr == DB);
               run_dn[f] = nr;
               if (block_mask[f] || service_mode || clear_down[f]) m_dn[f] = 0;
               else if (acc) m_dn[f] = 1;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [7:0] e_car;
      logic [6:0] e_up;
      logic [7:1] e_dn;
      int best;
      bit e_above, e_below, e_at;
      e_car = '0; e_up = '0; e_dn = '0;
      best = -1; e_above = 0; e_below = 0; e_at = 0;
      for (int f = 0; f < NF; f++) begin
         e_car[f] = m_car[f];
         if (f < NF - 1) e_up[f] = m_up[f];
         if (f > 0) e_dn[f] = m_dn[f];
         if (m_pend(f)) begin
            if (best < 0 || m_age[f] > m_age[best]) best = f;
            if (f > int'(current_floor)) e_above = 1;
            if (f < int'(current_floor)) e_below = 1;
            if (f == int'(current_floor)) e_at = 1;
         end
      end
      chk("car_calls", car_calls, e_car);
      chk("up_calls", up_calls, e_up);
      chk("down_calls", down_calls, e_dn);
      chk("any_above", any_above, e_above);
      chk("any_below", any_below, e_below);
      chk("any_at", any_at, e_at);
      chk("oldest_floor", oldest_floor, (best < 0) ? 0 : best);
      chk("oldest_valid", oldest_valid, best >= 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1;
      car_btn = '0; hall_up_btn = '0; hall_down_btn = '0;
      block_mask = '0; service_mode = 1'b0;
      clear_car = '0; clear_up = '0; clear_down = '0;
      current_floor = '0;
      car_btn_b = '0; current_floor_b = '0;
      for (int f = 0; f < NF; f++) begin
         run_car[f] = 0; run_up[f] = 0; run_dn[f] = 0;
         m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0; m_age[f] = 0;
      end
      @(negedge clk);
      ticks(3);
      chk("rst_car", car_calls, 0);
      chk("rst_oldest_valid", oldest_valid, 0);
      chk("rst_b_oldest", oldest_floor_b, 0);
      reset = 1'b0;

      // Short press is ignored; a long press is accepted exactly once.
      car_btn[3] = 1'b1; ticks(3); car_btn[3] = 1'b0; ticks(2);
      chk("short_press", car_calls, 8'h00);
      car_btn[3] = 1'b1; ticks(3);
      chk("pre_accept", car_calls, 8'h00);
      tick();
      chk("accept_4th_edge", car_calls, 8'h08);
      tick();
      clear_car = 8'h08; tick(); clear_car = '0;
      chk("car_cleared", car_calls, 8'h00);
      ticks(4);
      chk("no_reaccept", car_calls, 8'h00);
      car_btn[3] = 1'b0; tick();

      // Clear wins over a simultaneous acceptance on the same bit.
      hall_up_btn[2] = 1'b1; hall_down_btn[5] = 1'b1; ticks(4);
      hall_up_btn[2] = 1'b0; hall_down_btn[5] = 1'b0; tick();
      chk("up2_set", up_calls[2], 1);
      chk("down5_set", down_calls[5], 1);
      hall_up_btn[2] = 1'b1; ticks(3);
      clear_up[2] = 1'b1; tick(); clear_up = '0; hall_up_btn[2] = 1'b0;
      chk("press_clear_up2", up_calls[2], 0);
      chk("down5_kept", down_calls[5], 1);
      clear_down[5] = 1'b1; tick(); clear_down = '0;

      // Blocked floor drops its calls and loses new presses.
      car_btn = 8'h42; ticks(4); car_btn = '0;
      chk("car_1_6", car_calls, 8'h42);
      block_mask = 8'h40; tick();
      chk("block_drop", car_calls, 8'h02);
      car_btn[6] = 1'b1; ticks(5); car_btn[6] = 1'b0;
      chk("block_ignore", car_calls, 8'h02);
      block_mask = '0; tick();
      chk("block_not_deferred", car_calls, 8'h02);

      // Service mode clears and suppresses hall calls only.
      hall_up_btn[0] = 1'b1; hall_down_btn[4] = 1'b1; ticks(4);
      hall_up_btn[0] = 1'b0; hall_down_btn[4] = 1'b0;
      chk("hall_0_4", {up_calls[0], down_calls[4]}, 2'b11);
      service_mode = 1'b1; tick();
      chk("svc_up_drop", up_calls, 0);
      chk("svc_down_drop", down_calls, 0);
      hall_up_btn[3] = 1'b1; hall_down_btn[6] = 1'b1; car_btn[4] = 1'b1; ticks(5);
      hall_up_btn = '0; hall_down_btn = '0; car_btn = '0;
      chk("svc_up_ignored", up_calls, 0);
      chk("svc_car_ok", car_calls, 8'h12);
      service_mode = 1'b0; tick();

      // Reset mid-operation, with a button held through its release.
      car_btn[5] = 1'b1; tick();
      reset = 1'b1; ticks(2);
      chk("midrst_car", car_calls, 0);
      chk("midrst_valid", oldest_valid, 0);
      reset = 1'b0; ticks(3);
      chk("held_through_rst", car_calls, 0);
      tick();
      chk("held_full_count", car_calls, 8'h20);
      car_btn[5] = 1'b0; clear_car = 8'h20; tick(); clear_car = '0;

      // Age ordering and saturation.
      car_btn[2] = 1'b1; ticks(4); car_btn[2] = 1'b0; ticks(1);
      car_btn[7] = 1'b1; ticks(4); car_btn[7] = 1'b0;
      chk("oldest_2", oldest_floor, 2);
      clear_car = 8'h04; tick(); clear_car = '0;
      chk("oldest_7", oldest_floor, 7);
      ticks(300);
      car_btn[0] = 1'b1; ticks(4); car_btn[0] = 1'b0;
      chk("oldest_7_sat", oldest_floor, 7);
      ticks(280);
      chk("oldest_tie_low", oldest_floor, 0);
      clear_car = 8'h01; tick(); clear_car = 8'h80; tick(); clear_car = '0;

      // Direction summaries.
      current_floor = 3'd4; car_btn = 8'h50; ticks(4); car_btn = '0;
      chk("sum_at", any_at, 1);
      chk("sum_above", any_above, 1);
      chk("sum_below", any_below, 0);
      current_floor = 3'd0; #1;
      chk("sum_floor0_above", any_above, 1);
      chk("sum_floor0_at", any_at, 0);
      clear_car = 8'h10; tick(); clear_car = 8'h40; tick(); clear_car = '0;

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         for (int f = 0; f < 8; f++) if ($urandom_range(9) == 0) car_btn[f] = ~car_btn[f];
         for (int f = 0; f < 7; f++) if ($urandom_range(9) == 0) hall_up_btn[f] = ~hall_up_btn[f];
         for (int f = 1; f < 8; f++) if ($urandom_range(9) == 0) hall_down_btn[f] = ~hall_down_btn[f];
         clear_car  = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
         clear_up   = ($urandom_range(3) == 0) ? 7'(1 << $urandom_range(6)) : 7'h00;
         clear_down = ($urandom_range(3) == 0) ? 7'(1 << $urandom_range(6)) : 7'h00;
         if ($urandom_range(63) == 0) begin
            int b;
            b = int'($urandom_range(7));
            block_mask[b] = ~block_mask[b];
         end
         if ($urandom_range(99) == 0) service_mode = ~service_mode;
         current_floor = 3'($urandom_range(7));
         reset = ($urandom_range(499) == 0);
         tick();
      end
      reset = 1'b0;
      car_btn = '0; hall_up_btn = '0; hall_down_btn = '0;
      block_mask = '0; service_mode = 1'b0;
      clear_car = '0; clear_up = '0; clear_down = '0;
      tick();

      // Six-floor instance: single-sample acceptance and out-of-range cabin position.
      car_btn_b = 6'h04; tick(); car_btn_b = '0;
      chk("b_d1_accept", car_calls_b, 6'h04);
      current_floor_b = 3'd7; #1;
      chk("b_oor7_flags", {any_above_b, any_below_b, any_at_b}, 3'b000);
      current_floor_b = 3'd6; #1;
      chk("b_oor6_flags", {any_above_b, any_below_b, any_at_b}, 3'b000);
      current_floor_b = 3'd5; #1;
      chk("b_top_flags", {any_above_b, any_below_b, any_at_b}, 3'b010);
      current_floor_b = 3'd2; #1;
      chk("b_at_flags", {any_above_b, any_below_b, any_at_b}, 3'b001);
      chk("b_oldest", {oldest_valid_b, oldest_floor_b}, {1'b1, 3'd2});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
